// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and helpers for the IF1 fetch-address generator.
//   pc_state_e : BOOT / RUN / HALTED control states
//   pc_src_e   : which source drives the next fetch PC
//   align_pc   : clears the low log2(inc_bytes) bits of an address
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_e;

    typedef enum logic [2:0] {
        SRC_HOLD     = 3'd0,
        SRC_TRAP     = 3'd1,
        SRC_REDIRECT = 3'd2,
        SRC_RAS      = 3'd3,
        SRC_PRED     = 3'd4,
        SRC_SEQ      = 3'd5
    } pc_src_e;

    // Operates on a 64-bit container so any XLEN up to 64 can use it;
    // callers zero-extend the input and size-cast the result back.
    function automatic logic [63:0] align_pc(input logic [63:0] pc,
                                             input int unsigned inc_bytes);
        return pc & ~(64'(inc_bytes) - 64'd1);
    endfunction

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack used by pc_gen_unit when PC_RAS_EN
// is defined.
//   clk, reset_n : clock, asynchronous active-low reset
//   clear        : empty the stack (takes priority over push/pop)
//   push, pop    : push push_data / pop top; both together replace the top
//   push_data    : return address to push
//   top          : most recently pushed entry (valid when !empty)
//   empty        : no entries held
// When full, a push overwrites the oldest entry and the count saturates.
module pc_ras #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;   // next slot to write; top lives at wr_ptr-1
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  top_ptr;
    logic              do_pop;

    assign top_ptr = wr_ptr - 1'b1;
    assign top     = mem[top_ptr];
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            count  <= '0;
        end else if (push && do_pop) begin
            mem[top_ptr] <= push_data;
        end else if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + 1'b1;
            if (count != CNT_W'(DEPTH)) begin
                count <= count + 1'b1;
            end
        end else if (do_pop) begin
            wr_ptr <= top_ptr;
            count  <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: IF1 fetch-address generator.
// Holds the fetch PC and picks the next one by priority:
//   trap > EXE redirect > RAS return (PC_RAS_EN only) > predictor > PC+INC.
// Trap/redirect load even while stalled and raise flush_if for one cycle
// (registered, so it coincides with the redirected PC).
// Optional feature macro: PC_RAS_EN (return-address stack).
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   en_if1                       fetch advance enable (0 = stall)
//   trap_valid/trap_target       trap redirect
//   redirect_valid_exe/_target   EXE mispredict correction
//   pred_valid_if1/_target       predictor taken hint
//   call_if1, ret_if1            predecoded call/return at current PC
//   halt_req, resume_req         debug halt / resume
//   current_pc_if1, next_pc_if1  fetch PC, combinational next PC
//   pc_valid_if1, flush_if       valid fetch, redirect flush pulse
//   halted                       unit is HALTED
//   fsm_state                    control state for observation
module pc_gen_unit import pc_gen_pkg::*; #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      INC_BYTES    = 4,
    parameter int unsigned      RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en_if1,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            redirect_valid_exe,
    input  logic [XLEN-1:0] redirect_target_exe,
    input  logic            pred_valid_if1,
    input  logic [XLEN-1:0] pred_target_if1,
    input  logic            call_if1,
    input  logic            ret_if1,
    input  logic            halt_req,
    input  logic            resume_req,
    output logic [XLEN-1:0] current_pc_if1,
    output logic [XLEN-1:0] next_pc_if1,
    output logic            pc_valid_if1,
    output logic            flush_if,
    output logic            halted,
    output pc_state_e       fsm_state
);

    pc_state_e       state, state_next;
    pc_src_e         src;
    logic            in_run, active, redirect_taken, load_pc;
    logic            ras_hit;
    logic [XLEN-1:0] seq_pc, ras_top, next_pc;

    assign in_run  = (state == RUN);
    assign active  = (state == RUN) || (state == HALTED);
    assign seq_pc  = current_pc_if1 + XLEN'(INC_BYTES);

`ifdef PC_RAS_EN
    logic ras_empty, ras_push, ras_pop;

    assign ras_hit  = in_run && ret_if1 && !ras_empty;
    // Call/return only update the stack when the predicted path actually
    // advances; a trap or redirect in the same cycle discards them.
    assign ras_push = in_run && en_if1 && call_if1 && !redirect_taken;
    assign ras_pop  = ras_hit && en_if1 && !redirect_taken;

    pc_ras #(
        .DATA_W (XLEN),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (src == SRC_TRAP),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    logic unused_ras;
    assign unused_ras = ^{call_if1, ret_if1, 1'(RAS_DEPTH)};
    assign ras_hit    = 1'b0;
    assign ras_top    = '0;
`endif

    // Source select; BOOT and HALTED without a redirect hold the PC.
    always_comb begin
        src = SRC_HOLD;
        if (active && trap_valid) begin
            src = SRC_TRAP;
        end else if (active && redirect_valid_exe) begin
            src = SRC_REDIRECT;
        end else if (in_run) begin
            if (ras_hit)             src = SRC_RAS;
            else if (pred_valid_if1) src = SRC_PRED;
            else                     src = SRC_SEQ;
        end
    end

    always_comb begin
        next_pc = current_pc_if1;
        case (src)
            SRC_TRAP:     next_pc = XLEN'(align_pc(64'(trap_target), INC_BYTES));
            SRC_REDIRECT: next_pc = XLEN'(align_pc(64'(redirect_target_exe), INC_BYTES));
            SRC_RAS:      next_pc = XLEN'(align_pc(64'(ras_top), INC_BYTES));
            SRC_PRED:     next_pc = XLEN'(align_pc(64'(pred_target_if1), INC_BYTES));
            SRC_SEQ:      next_pc = seq_pc;
            default:      next_pc = current_pc_if1;
        endcase
    end

    assign redirect_taken = (src == SRC_TRAP) || (src == SRC_REDIRECT);
    assign load_pc        = redirect_taken || (in_run && en_if1);

    // A halt that coincides with a redirect is deferred by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt_req && !redirect_taken) state_next = HALTED;
            HALTED:  if (resume_req && !halt_req)     state_next = RUN;
            default: state_next = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= BOOT;
            current_pc_if1 <= RESET_VECTOR;
            flush_if       <= 1'b0;
        end else begin
            state    <= state_next;
            flush_if <= redirect_taken;
            if (load_pc) begin
                current_pc_if1 <= next_pc;
            end
        end
    end

    assign next_pc_if1  = next_pc;
    assign pc_valid_if1 = in_run;
    assign halted       = (state == HALTED);
    assign fsm_state    = state;

endmodule
